// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the async instruction
// memory and fills the IF/ID register with stall/redirect/fault handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rd,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_pc4,
    output logic              if_id_valid,
    output logic              fault,
    output logic [31:0]       fault_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [32:0] LIMIT = 33'(1) << (ADDR_W + 2);

    state_t      state;
    logic [31:0] pc;
    logic        pc_ok;
    logic        bad_tgt;

    assign imem_addr = pc[ADDR_W+1:2];
    assign pc_ok     = {1'b0, pc} < LIMIT;
    assign bad_tgt   = (|redirect_pc[1:0]) || !({1'b0, redirect_pc} < LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            fault       <= 1'b0;
            fault_pc    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                    if (redirect) begin
                        if (bad_tgt) begin
                            state <= HALT;
                            if (!fault) begin
                                fault    <= 1'b1;
                                fault_pc <= redirect_pc;
                            end
                        end else begin
                            pc <= redirect_pc;
                        end
                    end else if (fetch_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        if (bad_tgt) begin
                            state <= HALT;
                            if (!fault) begin
                                fault    <= 1'b1;
                                fault_pc <= redirect_pc;
                            end
                        end else begin
                            pc <= redirect_pc;
                        end
                    end else if (stall) begin
                        pc <= pc;
                    end else if (!fetch_en) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        state       <= IDLE;
                    end else if (!pc_ok) begin
                        // running off the end of memory is a fault, not a wrap
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        state       <= HALT;
                        if (!fault) begin
                            fault    <= 1'b1;
                            fault_pc <= pc;
                        end
                    end else begin
                        if_id_instr <= imem_rd;
                        if_id_pc    <= pc;
                        if_id_pc4   <= pc + 32'd4;
                        if_id_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                    end
                end
                HALT: begin
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                    if (redirect && !bad_tgt) begin
                        pc    <= redirect_pc;
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector tables fed through a
// scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fault;
    logic [31:0] fault_pc;

    int n_chk;
    int n_fail;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_pc4  (if_id_pc4),
        .if_id_valid(if_id_valid),
        .fault      (fault),
        .fault_pc   (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [9:0] w);
        return 32'h1000_0000 + {22'd0, w} * 32'h0001_0003;
    endfunction

    always_comb imem_rd = memval(imem_addr);

    typedef struct {
        logic        fe;
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] epc4;
        logic        ef;
        logic [31:0] efpc;
        logic [9:0]  ea;
    } vec_t;

    typedef struct {
        logic        ev;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        ef;
        logic [31:0] efpc;
        logic [9:0]  ea;
    } exp_t;

    vec_t vt1[$];
    vec_t vt2[$];
    exp_t sb[$];

    function automatic vec_t mk(
        input logic fe, input logic st, input logic rd, input logic [31:0] rpc,
        input logic ev, input logic [31:0] epc, input logic [31:0] epc4,
        input logic ef, input logic [31:0] efpc, input logic [9:0] ea);
        vec_t v;
        v.fe = fe; v.st = st; v.rd = rd; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.epc4 = epc4;
        v.ef = ef; v.efpc = efpc; v.ea = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t g;
        @(negedge clk);
        fetch_en    = v.fe;
        stall       = v.st;
        redirect    = v.rd;
        redirect_pc = v.rpc;
        e.ev    = v.ev;
        e.instr = v.ev ? memval(v.epc[11:2]) : NOP;
        e.pc    = v.epc;
        e.pc4   = v.epc4;
        e.ef    = v.ef;
        e.efpc  = v.efpc;
        e.ea    = v.ea;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty vec %0d: got 0 entries, want 1", idx);
        end else begin
            g = sb.pop_front();
            check($sformatf("v%0d valid", idx), 32'(if_id_valid), 32'(g.ev));
            check($sformatf("v%0d instr", idx), if_id_instr, g.instr);
            check($sformatf("v%0d pc", idx), if_id_pc, g.pc);
            check($sformatf("v%0d pc4", idx), if_id_pc4, g.pc4);
            check($sformatf("v%0d fault", idx), 32'(fault), 32'(g.ef));
            check($sformatf("v%0d fault_pc", idx), fault_pc, g.efpc);
            check($sformatf("v%0d imem_addr", idx), 32'(imem_addr), 32'(g.ea));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " valid"}, 32'(if_id_valid), 32'd0);
        check({tag, " instr"}, if_id_instr, NOP);
        check({tag, " pc"}, if_id_pc, 32'd0);
        check({tag, " pc4"}, if_id_pc4, 32'd0);
        check({tag, " fault"}, 32'(fault), 32'd0);
        check({tag, " fault_pc"}, fault_pc, 32'd0);
        check({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        fetch_en = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;

        // fe st rd rpc | valid pc pc4 fault fault_pc imem_addr
        vt1.push_back(mk(1,0,0,0,        0,32'h00,32'h04-4,0,0,0));
        vt1.push_back(mk(1,0,0,0,        1,32'h00,32'h04,0,0,1));
        vt1.push_back(mk(1,0,0,0,        1,32'h04,32'h08,0,0,2));
        vt1.push_back(mk(1,1,0,0,        1,32'h04,32'h08,0,0,2));
        vt1.push_back(mk(1,1,0,0,        1,32'h04,32'h08,0,0,2));
        vt1.push_back(mk(1,1,0,0,        1,32'h04,32'h08,0,0,2));
        vt1.push_back(mk(1,0,0,0,        1,32'h08,32'h0C,0,0,3));
        vt1.push_back(mk(1,1,1,32'h40,   0,32'h08,32'h0C,0,0,16));
        vt1.push_back(mk(1,0,0,0,        1,32'h40,32'h44,0,0,17));
        vt1.push_back(mk(1,0,1,32'h42,   0,32'h40,32'h44,1,32'h42,17));
        vt1.push_back(mk(1,0,0,0,        0,32'h40,32'h44,1,32'h42,17));
        vt1.push_back(mk(1,0,1,32'h2000, 0,32'h40,32'h44,1,32'h42,17));
        vt1.push_back(mk(1,0,1,32'h80,   0,32'h40,32'h44,1,32'h42,32));
        vt1.push_back(mk(1,0,0,0,        1,32'h80,32'h84,1,32'h42,33));
        vt1.push_back(mk(1,0,0,0,        1,32'h84,32'h88,1,32'h42,34));

        vt2.push_back(mk(0,0,1,32'hFF8,  0,32'h0,32'h0,0,0,1022));
        vt2.push_back(mk(1,0,0,0,        0,32'h0,32'h0,0,0,1022));
        vt2.push_back(mk(1,0,0,0,        1,32'hFF8,32'hFFC,0,0,1023));
        vt2.push_back(mk(1,0,0,0,        1,32'hFFC,32'h1000,0,0,0));
        vt2.push_back(mk(1,0,0,0,        0,32'hFFC,32'h1000,1,32'h1000,0));
        vt2.push_back(mk(1,0,1,32'h1000, 0,32'hFFC,32'h1000,1,32'h1000,0));
        vt2.push_back(mk(1,0,1,32'h4,    0,32'hFFC,32'h1000,1,32'h1000,1));
        vt2.push_back(mk(1,0,0,0,        1,32'h4,32'h8,1,32'h1000,2));
        vt2.push_back(mk(0,0,0,0,        0,32'h4,32'h8,1,32'h1000,2));
        vt2.push_back(mk(0,0,0,0,        0,32'h4,32'h8,1,32'h1000,2));

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vt1.size(); i++) apply(vt1[i], i);

        // async reset between edges while a valid instruction is held
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_vals("async_rst");
        fetch_en = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("idle valid", 32'(if_id_valid), 32'd0);
            check("idle imem_addr", 32'(imem_addr), 32'd0);
        end

        for (int i = 0; i < vt2.size(); i++) apply(vt2[i], 100 + i);

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
